secuencia_escritura_rtc: RTL and testbench
==========================================

SECUENCIA_ESCRITURA_RTC -- requirements
Module: secuencia_escritura_rtc

Interface
REQ-001 SHALL have parameter T_FASE, default 4, meaning ticks per bus phase (legal range 1..15).
REQ-002 SHALL have port reloj  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port resetM  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port inicio  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port dir  input  8  RTC register address to write.
REQ-006 SHALL have port dato  input  8  byte to write; this is the status byte produced by the status-modify stage (Mod_s).
REQ-007 SHALL have port tick  input  1  timebase enable; phase counter advances only when high.
REQ-008 SHALL have port AD_out  output  8  multiplexed address/data bus drive value.
REQ-009 SHALL have port AD_oe  output  1  bus output enable; 1 = drive AD_out.
REQ-010 SHALL have port CS_n  output  1  RTC chip select, active-low.
REQ-011 SHALL have port RD_n  output  1  RTC read strobe, active-low; constant 1 in this block.
REQ-012 SHALL have port WR_n  output  1  RTC write strobe, active-low.
REQ-013 SHALL have port A_D  output  1  0 = address phase, 1 = data phase or idle.
REQ-014 SHALL have port ocupado  output  1  high in every state except IDLE.
REQ-015 SHALL have port listo  output  1  one-clock completion pulse.

Function
REQ-016 SHALL implement states IDLE, A_SET, A_WR, A_HLD, PAUSA, D_SET, D_WR, D_HLD, FIN, in that order.
REQ-017 SHALL, in IDLE with inicio=1 at a rising edge, capture dir and dato into internal registers, clear the phase counter and enter A_SET on that edge.
REQ-018 SHALL keep every phase state (A_SET..D_HLD) for exactly T_FASE tick-qualified cycles: counter increments on tick=1; at tick=1 with counter=T_FASE-1, counter clears and the state advances.
REQ-019 SHALL hold state and counter unchanged on any cycle with tick=0.
REQ-020 SHALL stay in FIN for exactly one clock regardless of tick, then enter IDLE.
REQ-021 SHALL drive outputs as a pure function of the registered state and captured registers (no input-to-output combinational path).
REQ-022 SHALL drive IDLE, PAUSA and FIN as: CS_n=1, WR_n=1, A_D=1, AD_oe=0, AD_out=8'h00.
REQ-023 SHALL drive A_SET and A_HLD as: CS_n=0, WR_n=1, A_D=0, AD_oe=1, AD_out=captured dir; A_WR identical except WR_n=0.
REQ-024 SHALL drive D_SET and D_HLD as: CS_n=0, WR_n=1, A_D=1, AD_oe=1, AD_out=captured dato; D_WR identical except WR_n=0.
REQ-025 SHALL assert listo only in FIN.
REQ-026 SHALL ignore inicio in any non-IDLE state, including FIN; requests are not queued.
REQ-027 SHALL ignore changes on dir/dato after capture until the next accepted start.
REQ-028 SHALL, with tick held 1, give 28 clocks from accepting edge to entering FIN (7 phases x T_FASE), listo in clock 29, IDLE from clock 30; the earliest next acceptance is at the edge that enters IDLE+1 cycle.

Reset
REQ-029 SHALL, while resetM=0, force IDLE, counter=0, captured dir/dato=8'h00, and outputs to IDLE values with ocupado=0, listo=0, immediately and without waiting for reloj.
REQ-030 SHALL, on reset during any phase, abandon the transaction, release the bus and not emit listo.

Verification
REQ-031 SHALL be checked: T_FASE=4, tick=1, inicio pulse with dir=8'h0F, dato=8'h18 -> AD_out=0F with A_D=0 for 12 clocks, WR_n low for clocks 5..8, 4 idle-bus clocks, AD_out=18 with A_D=1 for 12 clocks, WR_n low for clocks 21..24, listo=1 at clock 29.
REQ-032 SHALL be checked: tick pulsing once every 3 clocks, T_FASE=2 -> each phase lasts 6 clocks; strobes never shorten or glitch.
REQ-033 SHALL be checked: inicio asserted again during D_WR and in FIN with dato=8'hFF -> ignored; single transaction completes with data 8'h18, one listo pulse.
REQ-034 SHALL be checked: resetM driven low mid-A_WR between clock edges -> CS_n=1, WR_n=1, AD_oe=0 asynchronously; no listo; fresh start after release completes normally.
REQ-035 SHALL be checked: T_FASE=1, tick=1 -> full transaction in 7 clocks plus FIN; dir/dato changed one cycle after start do not appear on AD_out.

Source files
------------

// File: rtl/secuencia_escritura_rtc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// secuencia_escritura_rtc : RTC write sequence on a multiplexed A/D bus
// Rev 1.0
// ----------------------------------------------------------------------------
module secuencia_escritura_rtc #(
  parameter int unsigned T_FASE = 4
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       inicio,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic       tick,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    A_SET = 4'd1,
    A_WR  = 4'd2,
    A_HLD = 4'd3,
    PAUSA = 4'd4,
    D_SET = 4'd5,
    D_WR  = 4'd6,
    D_HLD = 4'd7,
    FIN   = 4'd8
  } estado_t;

  localparam logic [3:0] C_ULTIMO = 4'(T_FASE - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      estado_q <= IDLE;
      cnt_q    <= 4'd0;
      dir_q    <= 8'h00;
      dato_q   <= 8'h00;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
    case (estado_q)
      IDLE: begin
        if (inicio) begin
          dir_d    = dir;
          dato_d   = dato;
          cnt_d    = 4'd0;
          estado_d = A_SET;
        end
      end
      FIN: estado_d = IDLE;
      default: begin
        // Phase states occupy consecutive encodings, so advancing is +1.
        if (tick) begin
          if (cnt_q == C_ULTIMO) begin
            cnt_d    = 4'd0;
            estado_d = estado_t'(estado_q + 4'd1);
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    AD_out  = 8'h00;
    AD_oe   = 1'b0;
    CS_n    = 1'b1;
    WR_n    = 1'b1;
    A_D     = 1'b1;
    ocupado = (estado_q != IDLE);
    listo   = 1'b0;
    case (estado_q)
      A_SET, A_WR, A_HLD: begin
        AD_out = dir_q;
        AD_oe  = 1'b1;
        CS_n   = 1'b0;
        A_D    = 1'b0;
        WR_n   = (estado_q != A_WR);
      end
      D_SET, D_WR, D_HLD: begin
        AD_out = dato_q;
        AD_oe  = 1'b1;
        CS_n   = 1'b0;
        WR_n   = (estado_q != D_WR);
      end
      FIN:     listo = 1'b1;
      default: ;
    endcase
  end

  assign RD_n = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_secuencia_escritura_rtc.sv
`default_nettype none
// Randomized bench for secuencia_escritura_rtc: three instances (T_FASE 4/2/1)
// share stimulus and are compared each clock against a tick-count model.
module tb_secuencia_escritura_rtc;

  logic       reloj = 1'b0;
  logic       resetM, inicio, tick;
  logic [7:0] dir, dato;

  logic [7:0] ad_out  [3];
  logic       ad_oe   [3];
  logic       cs_n    [3];
  logic       rd_n    [3];
  logic       wr_n    [3];
  logic       a_d     [3];
  logic       ocupado [3];
  logic       listo   [3];

  always #5 reloj = ~reloj;

  secuencia_escritura_rtc #(.T_FASE(4)) u_t4 (
    .reloj(reloj), .resetM(resetM), .inicio(inicio), .dir(dir), .dato(dato), .tick(tick),
    .AD_out(ad_out[0]), .AD_oe(ad_oe[0]), .CS_n(cs_n[0]), .RD_n(rd_n[0]),
    .WR_n(wr_n[0]), .A_D(a_d[0]), .ocupado(ocupado[0]), .listo(listo[0]));

  secuencia_escritura_rtc #(.T_FASE(2)) u_t2 (
    .reloj(reloj), .resetM(resetM), .inicio(inicio), .dir(dir), .dato(dato), .tick(tick),
    .AD_out(ad_out[1]), .AD_oe(ad_oe[1]), .CS_n(cs_n[1]), .RD_n(rd_n[1]),
    .WR_n(wr_n[1]), .A_D(a_d[1]), .ocupado(ocupado[1]), .listo(listo[1]));

  secuencia_escritura_rtc #(.T_FASE(1)) u_t1 (
    .reloj(reloj), .resetM(resetM), .inicio(inicio), .dir(dir), .dato(dato), .tick(tick),
    .AD_out(ad_out[2]), .AD_oe(ad_oe[2]), .CS_n(cs_n[2]), .RD_n(rd_n[2]),
    .WR_n(wr_n[2]), .A_D(a_d[2]), .ocupado(ocupado[2]), .listo(listo[2]));

  // Model: a transaction is just a count of tick-qualified cycles since start.
  int         tf [3] = '{4, 2, 1};
  bit         m_act [3];
  bit         m_fin [3];
  int         m_e   [3];
  logic [7:0] m_dir [3];
  logic [7:0] m_dato[3];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 0; m_fin[k] = 0; m_e[k] = 0; m_dir[k] = 8'h00; m_dato[k] = 8'h00;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      if (!resetM) begin
        m_act[k] = 0; m_fin[k] = 0; m_e[k] = 0; m_dir[k] = 8'h00; m_dato[k] = 8'h00;
      end else if (m_fin[k]) begin
        m_fin[k] = 0;
      end else if (m_act[k]) begin
        if (tick) begin
          m_e[k]++;
          if (m_e[k] == 7 * tf[k]) begin
            m_act[k] = 0; m_fin[k] = 1; m_e[k] = 0;
          end
        end
      end else if (inicio) begin
        m_act[k] = 1; m_e[k] = 0; m_dir[k] = dir; m_dato[k] = dato;
      end
    end
  endfunction

  // Packed as {AD_out, AD_oe, CS_n, RD_n, WR_n, A_D, ocupado, listo}
  function automatic logic [15:0] expected(int k);
    int p;
    if (m_fin[k]) return {1'b0, 8'h00, 7'b0111111};
    if (!m_act[k]) return {1'b0, 8'h00, 7'b0111100};
    p = m_e[k] / tf[k];
    if (p == 3) return {1'b0, 8'h00, 7'b0111110};
    if (p < 3)  return {1'b0, m_dir[k],  1'b1, 1'b0, 1'b1, 1'(p != 1), 1'b0, 1'b1, 1'b0};
    return {1'b0, m_dato[k], 1'b1, 1'b0, 1'b1, 1'(p != 5), 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic logic [15:0] observed(int k);
    return {1'b0, ad_out[k], ad_oe[k], cs_n[k], rd_n[k], wr_n[k], a_d[k], ocupado[k], listo[k]};
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("%s T%0d cyc%0d", tag, tf[k], cyc), observed(k), expected(k));
  endtask

  task automatic step(input string tag);
    @(posedge reloj);
    model_step();
    #1;
    cyc++;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 resetM = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge reloj) resetM = 1'b1;
  endtask

  initial begin
    resetM = 1'b0; inicio = 1'b0; tick = 1'b0; dir = 8'h00; dato = 8'h00;
    model_reset();
    #2 check_all("reset");
    @(negedge reloj) resetM = 1'b1;

    // Nominal write 0F/18; inputs scrambled after capture; late requests ignored.
    tick = 1'b1; dir = 8'h0F; dato = 8'h18; inicio = 1'b1;
    step("start");
    inicio = 1'b0; dir = 8'(($urandom)); dato = 8'(($urandom));
    for (int i = 1; i < 34; i++) begin
      inicio = (i == 21 || i == 22 || i == 28);
      if (inicio) dato = 8'hFF;
      step("nominal");
    end
    inicio = 1'b0;
    for (int i = 0; i < 6; i++) step("drain");

    // Sparse timebase: one tick every 3 clocks.
    dir = 8'hA5; dato = 8'h3C;
    for (int i = 0; i < 90; i++) begin
      tick = (i % 3 == 0);
      inicio = (i == 1);
      step("sparse");
    end

    // Reset asserted between edges while the T_FASE=4 instance is in A_WR.
    tick = 1'b1; inicio = 1'b1; dir = 8'h55; dato = 8'hAA;
    step("rst_start");
    inicio = 1'b0;
    for (int i = 0; i < 5; i++) step("rst_run");
    async_reset("async_rst");
    for (int i = 0; i < 3; i++) step("rst_idle");
    inicio = 1'b1; dir = 8'h12; dato = 8'h34;
    step("restart");
    inicio = 1'b0;
    for (int i = 0; i < 32; i++) step("restart_run");

    for (int i = 0; i < 2000; i++) begin
      tick   = ($urandom_range(0, 3) != 0);
      inicio = ($urandom_range(0, 5) == 0);
      dir    = 8'($urandom);
      dato   = 8'($urandom);
      step("rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
